// File: rtl/dual_bank_regfile_if.sv
// Register-file access bundle: write controls, read indices and the two read buses.
// The datapath drives the master side and the register file is the slave.
interface dual_bank_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              write;
    logic              regdst;
    logic              fpoint;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] busW;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;

    modport master (
        output write, regdst, fpoint, rd, rs, rt, busW,
        input  busA, busB
    );

    modport slave (
        input  write, regdst, fpoint, rd, rs, rt, busW,
        output busA, busB
    );
endinterface

// File: rtl/dual_bank_regfile.sv
// Integer + floating-point register banks with two combinational read ports.
// There is one write port, and it commits on the falling clock edge.
module dual_bank_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    dual_bank_regfile_if.slave bus
);
    logic [DATA_W-1:0] r_int [NREGS];
    logic [DATA_W-1:0] r_fp  [NREGS];
    logic [ADDR_W-1:0] w_dest;

    assign w_dest = bus.regdst ? bus.rd : bus.rt;

    // Writes to integer r0 are dropped, so the stored word stays zero as well.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_int[i] <= '0;
                r_fp[i]  <= '0;
            end
        end else if (bus.write) begin
            if (bus.fpoint) begin
                r_fp[w_dest] <= bus.busW;
            end else if (w_dest != '0) begin
                r_int[w_dest] <= bus.busW;
            end
        end
    end

    always_comb begin
        bus.busA = '0;
        bus.busB = '0;
        if (bus.fpoint) begin
            bus.busA = r_fp[bus.rs];
            bus.busB = r_fp[bus.rt];
        end else begin
            if (bus.rs != '0) bus.busA = r_int[bus.rs];
            if (bus.rt != '0) bus.busB = r_int[bus.rt];
        end
    end
endmodule

// File: tb/tb_dual_bank_regfile.sv
// Scoreboarded bench: stimulus queues expected read-bus values from an array model,
// and a monitor process pops and compares each time a read sample is presented.
module tb_dual_bank_regfile;
    logic clk;
    logic rst_n;

    dual_bank_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    dual_bank_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        q[$];
    event        smp;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] int_m [32];
    logic [31:0] fp_m  [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    // Architectural view: integer r0 reads zero, everything else is plain storage.
    function automatic logic [31:0] model_rd(logic f, logic [4:0] idx);
        if (f) return fp_m[idx];
        if (idx == 5'd0) return 32'd0;
        return int_m[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            int_m[i] = 32'd0;
            fp_m[i]  = 32'd0;
        end
    endtask

    task automatic expect_rd(string nm);
        exp_t e;
        e.nm = nm;
        e.a  = model_rd(bus.fpoint, bus.rs);
        e.b  = model_rd(bus.fpoint, bus.rt);
        q.push_back(e);
        -> smp;
        #1;
    endtask

    task automatic do_read(string nm, logic f, logic [4:0] a, logic [4:0] b);
        bus.fpoint = f;
        bus.rs     = a;
        bus.rt     = b;
        #1;
        expect_rd(nm);
    endtask

    task automatic do_write(logic f, logic dst, logic [4:0] d_rd, logic [4:0] d_rt,
                            logic [31:0] data);
        logic [4:0] dest;
        @(posedge clk);
        #1;
        bus.write  = 1'b1;
        bus.fpoint = f;
        bus.regdst = dst;
        bus.rd     = d_rd;
        bus.rt     = d_rt;
        bus.busW   = data;
        @(negedge clk);
        dest = dst ? d_rd : d_rt;
        if (f) fp_m[dest] = data;
        else int_m[dest] = data;
        #1;
        bus.write = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(smp);
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: sample with empty queue busA=%h busB=%h",
                         bus.busA, bus.busB);
            end else begin
                e = q.pop_front();
                if (bus.busA !== e.a || bus.busB !== e.b) begin
                    miscompares++;
                    $display("FAIL %s: fp=%0b rs=%0d rt=%0d busA=%h want %h busB=%h want %h",
                             e.nm, bus.fpoint, bus.rs, bus.rt, bus.busA, e.a, bus.busB, e.b);
                end
            end
        end
    end

    initial begin
        logic [4:0] d;
        rst_n      = 1'b0;
        bus.write  = 1'b0;
        bus.regdst = 1'b1;
        bus.fpoint = 1'b0;
        bus.rd     = '0;
        bus.rs     = '0;
        bus.rt     = '0;
        bus.busW   = '0;
        model_clear();
        #12;
        rst_n = 1'b1;
        #1;
        do_read("reset_int", 1'b0, 5'd7, 5'd31);
        do_read("reset_fp", 1'b1, 5'd0, 5'd31);

        // 1
        do_write(1'b0, 1'b1, 5'd1, 5'd0, 32'd1);
        do_read("t1_r1", 1'b0, 5'd1, 5'd1);
        // 2
        do_write(1'b0, 1'b1, 5'd2, 5'd0, 32'd2);
        do_read("t2_r1r2", 1'b0, 5'd1, 5'd2);
        // 3
        do_write(1'b1, 1'b1, 5'd20, 5'd0, 32'd20);
        do_read("t3_int", 1'b0, 5'd2, 5'd5);
        do_read("t3_fp", 1'b1, 5'd20, 5'd20);
        // 4: destination taken from rt, rd left at 2
        do_write(1'b0, 1'b0, 5'd2, 5'd5, 32'd5);
        do_read("t4_rt_dest", 1'b0, 5'd5, 5'd2);
        // 5
        do_write(1'b0, 1'b1, 5'd0, 5'd0, 32'hDEADBEEF);
        do_read("t5_r0", 1'b0, 5'd0, 5'd0);
        do_write(1'b1, 1'b1, 5'd0, 5'd0, 32'd7);
        do_read("t5_f0", 1'b1, 5'd0, 5'd0);
        do_read("t5_r0_again", 1'b0, 5'd0, 5'd1);

        // Random traffic: old value before the commit edge, new value right after.
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            bus.write  = ($urandom_range(0, 3) != 0);
            bus.fpoint = $urandom_range(0, 1);
            bus.regdst = $urandom_range(0, 1);
            bus.rd     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.rt     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.rs     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.busW   = $urandom;
            #1;
            expect_rd("rdw_old");
            @(negedge clk);
            d = bus.regdst ? bus.rd : bus.rt;
            if (bus.write) begin
                if (bus.fpoint) fp_m[d] = bus.busW;
                else int_m[d] = bus.busW;
            end
            #1;
            expect_rd("rdw_new");
            bus.write = 1'b0;
            bus.fpoint = ~bus.fpoint;
            #1;
            expect_rd("other_bank");
        end

        // 6: load known values, then asynchronous reset with a write pending.
        do_write(1'b0, 1'b1, 5'd3, 5'd0, 32'h1234_5678);
        do_write(1'b1, 1'b1, 5'd3, 5'd0, 32'h8765_4321);
        do_read("t6_loaded", 1'b0, 5'd3, 5'd3);
        @(posedge clk);
        #2;
        bus.write  = 1'b1;
        bus.fpoint = 1'b0;
        bus.regdst = 1'b1;
        bus.rd     = 5'd3;
        bus.rs     = 5'd3;
        bus.rt     = 5'd3;
        bus.busW   = 32'hCAFE_F00D;
        rst_n      = 1'b0;
        model_clear();
        #1;
        expect_rd("t6_async_clear");
        @(negedge clk);
        #1;
        expect_rd("t6_write_in_reset");
        bus.write = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i += 4) begin
            do_read("t6_after_int", 1'b0, 5'(i), 5'(i + 3));
            do_read("t6_after_fp", 1'b1, 5'(i + 1), 5'(i + 2));
        end

        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
